fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
// - Consumer end of the fifoConnect interface: drives the reader modport of a fifo core, pops words
//   and presents them on a valid/ready stream with full throughput and back-pressure.
// - Hides the one-cycle registered dataout latency behind a 2-entry skid buffer.
// - Marks burst boundaries (last) every BURSTLEN words; provides enable/stop control and a pop count.
// PARAMETERS
// - WIDTH      32  data width; equals link WIDTH
// - DEPTH      32  depth of the attached fifo; equals link DEPTH, carried for the fillLevel width only
// - BURSTLEN   16  words per burst; last asserted on word BURSTLEN-1; >=1
// - COUNTBITS  32  width of wordCount
// PORTS
// - clk        in   1          single clock, all logic on posedge
// - reset_n    in   1          asynchronous, active-low reset
// - enable     in   1          1 = issue reads; 0 = stop issuing, drain in-flight words
// - link       --   fifoConnect.reader  drives read; write=0 and datain='0 held constant
// - out_data   out  WIDTH      stream data
// - out_valid  out  1          stream data valid
// - out_ready  in   1          downstream accept; transfer = out_valid & out_ready
// - out_last   out  1          burst boundary, qualified by out_valid
// - busy       out  1          1 while words are in flight or buffered
// - wordCount  out  COUNTBITS  words transferred on the stream; wraps modulo 2^COUNTBITS
// BEHAVIOUR
// - Reset (reset_n=0, asynchronous): link.read=0, out_valid=0, out_data='0, out_last=0, busy=0,
//   wordCount=0, burst counter=0, skid buffer empty, inflight=0, state=STOPPED.
// - Fifo contract: link.dataout is valid one cycle after a cycle with link.read=1 while
//   link.fillStatus.empty=0. fillStatus.empty is registered and exact each cycle.
// - Read issue, combinational: link.read = (state==RUN) & !link.fillStatus.empty &
//   (occ + inflight - pop < 2). occ = skid entries (0..2). inflight = read issued last cycle (0/1).
//   pop = out_valid & out_ready.
// - The skid buffer never overflows. A read is never issued while empty=1.
// - Capture: inflight=1 -> link.dataout written to the skid tail in the current cycle.
// - Output: out_data/out_valid come from the skid head, registered. Order is strict FIFO.
// - Throughput: with the fifo non-empty and out_ready=1, one word per cycle sustained.
//   First out_valid appears 2 cycles after empty falls.
// - Back-pressure: out_valid and out_data stay stable while out_ready=0.
//   Reads stop once occ+inflight=2.
// - Burst counter (BURSTLEN range): +1 per transfer; out_last = (burstCnt==BURSTLEN-1).
//   It wraps to 0 after the last transfer. BURSTLEN=1 -> out_last=1 on every word.
// - wordCount: +1 per transfer, modulo wrap, no saturation.
// - FSM: STOPPED, RUN, STOPPING.
//   - STOPPED -> RUN when enable=1.
//   - RUN -> STOPPING when enable=0.
//   - STOPPING issues no reads. STOPPING -> STOPPED when occ=0 & inflight=0.
//   - STOPPING -> RUN when enable=1 again.
//   - busy = (occ!=0) | inflight.
// - Burst counter is NOT cleared by stop/start; bursts continue across pauses.
// - Simultaneous capture+pop with occ=2 cannot occur (read guard). Capture+pop with occ=1: occ stays 1.
// - Reset mid-operation discards buffered/in-flight words. The fifo side is reset separately by its owner.
// STRUCTURE
// - fifoPkg: add typedef enum logic [1:0] {RD_STOPPED, RD_RUN, RD_STOPPING} readerState.
// - Sub-module fifo_skid_buffer #(WIDTH): 2-entry register buffer, push/pop/occ, async active-low reset.
//   The top holds the FSM, read-issue guard, inflight flag and counters.
// TESTING
// - Preload 8 words 0x1..0x8, enable=1, out_ready=1 -> 8 transfers on 8 consecutive cycles,
//   data 0x1..0x8, wordCount=8, no read while empty=1.
// - BURSTLEN=4, 10 words -> out_last on words 4 and 8 only; burst counter=2 at end.
// - out_ready toggled 1,0,0,1 pseudo-random over 100 words -> every word once, in order;
//   out_data stable while stalled; link.read never high with occ+inflight=2.
// - enable dropped after 3 words of 20 -> at most 2 more words out, busy falls, state STOPPED, fifo fill=15;
//   re-enable -> remaining 15 words delivered in order.
// - Fifo written one word every 5 cycles -> each word out 2 cycles after empty falls, no duplicates/stale data.
// - reset_n pulsed low mid-stream with occ=2 -> outputs clear immediately (async); wordCount=0, out_valid=0.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// Shared types for the fifo stream reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_stream_reader_pkg;

    // Reader control states: idle, issuing reads, draining in-flight words.
    typedef enum logic [1:0] {
        RD_STOPPED  = 2'd0,
        RD_RUN      = 2'd1,
        RD_STOPPING = 2'd2
    } readerState;

    // Number of words the reader may hold buffered plus in flight.
    localparam int SKID_ENTRIES = 2;

    // Width of a counter that spans 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_connect_if.sv
// Link between a fifo core and its writer/reader clients.
// Latency: dataout is registered, valid one cycle after an accepted read.
// Backpressure: fillStatus.empty/full are registered and exact each cycle.
interface fifoConnect #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    typedef struct packed {
        logic                           empty;
        logic                           full;
        logic [$clog2(DEPTH+1)-1:0]     fillLevel;
    } fill_status_t;

    logic               read;
    logic               write;
    logic [WIDTH-1:0]   datain;
    logic [WIDTH-1:0]   dataout;
    fill_status_t       fillStatus;

    modport writer (output write, datain, input fillStatus);
    modport reader (output read, write, datain, input dataout, fillStatus);
    modport core   (input read, write, datain, output dataout, fillStatus);
endinterface

// File: rtl/fifo_skid_buffer.sv
// Two-entry register buffer; head entry is the registered stream output.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: head holds while not popped; caller must not push into a full buffer.
module fifo_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_head_vld,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_occ;
    logic             w_pop;
    logic             w_push;

    // A pop needs a word at the head; a push needs room after any same-cycle pop.
    assign w_pop  = i_pop & (r_occ != 2'd0);
    assign w_push = i_push & ((r_occ != 2'd2) | w_pop);

    // Shift/fill the two entries so the oldest word always sits in r_head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= i_push_dat;
                    end else begin
                        r_tail <= i_push_dat;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_push_dat;
                    end else begin
                        r_head <= i_push_dat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head_dat = r_head;
    assign o_head_vld = (r_occ != 2'd0);
    assign o_occ      = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a fifo core through its reader link and streams the words out as valid/ready.
// Latency: first word valid 2 cycles after fifo empty falls; 1 word/cycle sustained.
// Backpressure: out_valid/out_data hold while out_ready=0; reads stop at 2 words buffered+in flight.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int BURSTLEN  = 16,
    parameter int COUNTBITS = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    fifoConnect.reader           link,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic [COUNTBITS-1:0] wordCount
);

    localparam int             BW        = cnt_width(BURSTLEN);
    localparam logic [BW-1:0]  BURST_MAX = BW'(BURSTLEN - 1);

    readerState             r_state;
    readerState             w_state_nxt;
    logic                   r_inflight;
    logic [BW-1:0]          r_burst_cnt;
    logic [COUNTBITS-1:0]   r_word_cnt;
    logic [1:0]             w_occ;
    logic                   w_head_vld;
    logic                   w_pop;
    logic                   w_read;
    logic [2:0]             w_pending;

    // Words that will still be held after this cycle's transfer, excluding a new read.
    assign w_pop     = w_head_vld & out_ready;
    assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_read    = (r_state == RD_RUN) & ~link.fillStatus.empty
                     & (w_pending < 3'(SKID_ENTRIES));

    assign link.read   = w_read;
    assign link.write  = 1'b0;
    assign link.datain = '0;

    // The word read last cycle lands in the skid tail this cycle.
    fifo_skid_buffer #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push     (r_inflight),
        .i_push_dat (link.dataout),
        .i_pop      (w_pop),
        .o_head_dat (out_data),
        .o_head_vld (w_head_vld),
        .o_occ      (w_occ)
    );

    assign out_valid = w_head_vld;
    assign out_last  = w_head_vld & (r_burst_cnt == BURST_MAX);
    assign busy      = (w_occ != 2'd0) | r_inflight;
    assign wordCount = r_word_cnt;

    // State register plus the one-cycle read-in-flight flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RD_STOPPED;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_read;
        end
    end

    // Next state: stopping drains everything in flight before going idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RD_STOPPED: begin
                if (enable) begin
                    w_state_nxt = RD_RUN;
                end
            end
            RD_RUN: begin
                if (!enable) begin
                    w_state_nxt = RD_STOPPING;
                end
            end
            RD_STOPPING: begin
                if (enable) begin
                    w_state_nxt = RD_RUN;
                end else if (!busy) begin
                    w_state_nxt = RD_STOPPED;
                end
            end
            default: begin
                w_state_nxt = RD_STOPPED;
            end
        endcase
    end

    // Burst position and total word count advance on every stream transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_burst_cnt <= '0;
            r_word_cnt  <= '0;
        end else if (w_pop) begin
            r_burst_cnt <= (r_burst_cnt == BURST_MAX) ? '0 : r_burst_cnt + 1'b1;
            r_word_cnt  <= r_word_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: behavioural fifo model feeds the reader, a monitor checks the stream.
// Latency: n/a.
// Backpressure: out_ready driven both steady and randomly.
module tb_fifo_stream_reader;
    import fifo_stream_reader_pkg::*;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int BL = 4;
    localparam int CB = 7;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic [CB-1:0] wordCount;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifoConnect #(.WIDTH(W), .DEPTH(D)) link ();

    fifo_stream_reader #(
        .WIDTH(W), .DEPTH(D), .BURSTLEN(BL), .COUNTBITS(CB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .link(link),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .wordCount(wordCount)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural fifo core ----------------
    logic [W-1:0] fq[$];
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_dat = '0;
    logic         rd_smp = 1'b0;
    int           cyc = 0;
    int           t_fall = 0;
    int           n_reads = 0;

    always @(negedge clk) rd_smp <= link.read;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fq.delete();
            n_reads = 0;
            link.dataout <= '0;
            link.fillStatus.empty <= 1'b1;
            link.fillStatus.full <= 1'b0;
            link.fillStatus.fillLevel <= '0;
        end else begin
            cyc++;
            if (rd_smp && fq.size() != 0) begin
                link.dataout <= fq.pop_front();
                n_reads++;
            end
            if (wr_en && fq.size() < D) fq.push_back(wr_dat);
            if (link.fillStatus.empty && fq.size() != 0) t_fall = cyc;
            link.fillStatus.empty <= (fq.size() == 0);
            link.fillStatus.full <= (fq.size() == D);
            link.fillStatus.fillLevel <= 6'(fq.size());
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [W-1:0] sb[$];
    int           n_done = 0;
    int           n_last = 0;
    int           first_xfer = 0;
    int           last_xfer = 0;
    bit           chk_lat = 1'b0;
    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic [W-1:0] pd = '0;

    always @(negedge clk) begin
        int           outst;
        logic         pop;
        logic [W-1:0] exp_d;
        if (!reset_n) begin
            sb.delete();
            n_done = 0;
            n_last = 0;
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            outst = n_reads - n_done;
            pop   = out_valid & out_ready;
            chk("wordCount", 64'(wordCount), 64'(n_done % (1 << CB)));
            chk("busy", 64'(busy), 64'(outst != 0));
            chk("no_overflow", 64'(outst <= 2), 64'd1);
            chk("read_while_empty", 64'(link.read & link.fillStatus.empty), 64'd0);
            chk("link_write_idle", {link.write, |link.datain}, 64'd0);
            if (link.read) chk("read_guard", 64'((outst - int'(pop)) < 2), 64'd1);
            if (pv && !pr) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(pd));
            end
            if (chk_lat && out_valid && !pv) chk("first_latency", 64'(cyc - t_fall), 64'd2);
            if (pop) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    exp_d = sb.pop_front();
                    chk("data", 64'(out_data), 64'(exp_d));
                end
                chk("last", 64'(out_last), 64'((n_done % BL) == BL - 1));
                if (out_last) n_last++;
                n_done++;
                if (n_done == 1) first_xfer = cyc;
                last_xfer = cyc;
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [W-1:0] d);
        wr_en  = 1'b1;
        wr_dat = d;
        sb.push_back(d);
        tick();
        wr_en  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        wr_en     = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while ((sb.size() != 0 || busy || fq.size() != 0) && k < 3000) begin
            tick();
            k++;
        end
        chk({nm, "_drain_in_time"}, 64'(k < 3000), 64'd1);
    endtask

    initial begin
        int k;
        int sent;
        int base;
        logic [W-1:0] d;

        // Reset state.
        do_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(wordCount), 64'd0);
        chk("rst_read", 64'(link.read), 64'd0);
        chk("rst_state", 64'(dut.r_state), 64'(RD_STOPPED));

        // Preloaded 8 words stream out on consecutive cycles.
        for (int i = 1; i <= 8; i++) put(W'(i));
        out_ready = 1'b1;
        enable    = 1'b1;
        wait_idle("p1");
        chk("p1_wordcount", 64'(wordCount), 64'd8);
        chk("p1_span", 64'(last_xfer - first_xfer), 64'd7);

        // Burst marking from a fresh reset: 10 words -> last on words 4 and 8.
        do_reset();
        out_ready = 1'b1;
        enable    = 1'b1;
        for (int i = 0; i < 10; i++) put(W'(32'h100 + i));
        wait_idle("p2");
        chk("p2_lasts", 64'(n_last), 64'd2);
        chk("p2_burst_cnt", 64'(dut.r_burst_cnt), 64'd2);

        // Random back-pressure and random write spacing, 100 words.
        sent = 0;
        k = 0;
        while ((sent < 100 || sb.size() != 0) && k < 5000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 100 && $urandom_range(0, 1) == 1 && fq.size() < D - 2) begin
                d = $urandom;
                wr_en  = 1'b1;
                wr_dat = d;
                sb.push_back(d);
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            k++;
        end
        wr_en     = 1'b0;
        out_ready = 1'b1;
        chk("p3_in_time", 64'(k < 5000), 64'd1);
        wait_idle("p3");

        // Stop after the third of 20 words, then resume.
        enable = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 20; i++) put(W'(32'h200 + i));
        base   = n_done;
        enable = 1'b1;
        k = 0;
        while (!(out_valid && (n_done - base) == 2) && k < 200) begin
            tick();
            k++;
        end
        enable = 1'b0;
        chk("p4_third_seen", 64'(k < 200), 64'd1);
        k = 0;
        while ((dut.r_state != RD_STOPPED || busy) && k < 200) begin
            tick();
            k++;
        end
        chk("p4_stopped_in_time", 64'(k < 200), 64'd1);
        chk("p4_words_out", 64'(n_done - base), 64'd5);
        chk("p4_fill", 64'(fq.size()), 64'd15);
        chk("p4_state", 64'(dut.r_state), 64'(RD_STOPPED));
        chk("p4_busy", 64'(busy), 64'd0);
        repeat (5) tick();
        chk("p4_quiet", 64'(n_done - base), 64'd5);
        enable = 1'b1;
        wait_idle("p4");
        chk("p4_total", 64'(n_done - base), 64'd20);

        // Sparse writes: each word appears 2 cycles after empty falls.
        chk_lat = 1'b1;
        for (int i = 0; i < 10; i++) begin
            put(W'(32'h300 + i));
            repeat (4) tick();
        end
        wait_idle("p5");
        chk_lat = 1'b0;

        // Asynchronous reset with both skid entries full.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(W'(32'h400 + i));
        k = 0;
        while (dut.u_skid.r_occ != 2'd2 && k < 50) begin
            tick();
            k++;
        end
        chk("p6_occ2_reached", 64'(k < 50), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("p6_valid", 64'(out_valid), 64'd0);
        chk("p6_data", 64'(out_data), 64'd0);
        chk("p6_count", 64'(wordCount), 64'd0);
        chk("p6_busy", 64'(busy), 64'd0);
        chk("p6_read", 64'(link.read), 64'd0);
        tick();
        enable    = 1'b0;
        reset_n   = 1'b1;
        tick();
        out_ready = 1'b1;
        enable    = 1'b1;
        for (int i = 0; i < 3; i++) put(W'(32'h500 + i));
        wait_idle("p6");
        chk("p6_post_count", 64'(wordCount), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
